// File: rtl/morse_uart_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// morse_uart_tx : buffers decoded Morse characters and sends them as 8N1 UART.
// Option macro MORSE_TX_INVALID_EN: send unrecognised codes (8'h00) as '?'.
// Revision: 1.0
// ---------------------------------------------------------------------------
module morse_uart_tx #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    letter_in,
  input  logic                          letter_stb,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int AW           = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  baud_cnt, baud_cnt_n;
  logic [2:0]        bit_idx, bit_idx_n;
  logic [7:0]        shift_reg, shift_reg_n;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [7:0]        map_code;
  logic              map_valid;
  logic              full;
  logic              push;
  logic              pop;
  logic              bit_end;

  always_comb begin
    map_code  = letter_in;
    map_valid = 1'b1;
    if (letter_in == 8'hFF) begin
      map_code = 8'h20;
    end else if (letter_in == 8'h00) begin
`ifdef MORSE_TX_INVALID_EN
      map_code = 8'h3F;
`else
      map_valid = 1'b0;
`endif
    end
  end

  // Full is judged on the registered count, so a same-cycle pop never frees room.
  assign full = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign push = letter_stb && map_valid && !full;
  assign pop  = (state == IDLE) && (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (letter_stb && map_valid && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= map_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_cnt_n;
      bit_idx   <= bit_idx_n;
      shift_reg <= shift_reg_n;
    end
  end

  assign bit_end = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_n     = state;
    baud_cnt_n  = baud_cnt;
    bit_idx_n   = bit_idx;
    shift_reg_n = shift_reg;
    tx          = 1'b1;
    case (state)
      IDLE: begin
        if (pop) begin
          shift_reg_n = mem[rd_ptr];
          baud_cnt_n  = '0;
          state_n     = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_end) begin
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        tx = shift_reg[0];
        if (bit_end) begin
          baud_cnt_n  = '0;
          shift_reg_n = shift_reg >> 1;
          bit_idx_n   = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          state_n    = IDLE;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign tx_busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_morse_uart_tx.sv
`default_nettype none
// Scoreboard bench for morse_uart_tx: stimulus queues expected bytes, a UART
// receiver process decodes tx and checks each frame against the queue.
module tb_morse_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] letter_in;
  logic       letter_stb;
  logic       tx;
  logic       tx_busy;
  logic [4:0] fifo_count;
  logic       overflow;

  morse_uart_tx #(.CLK_FREQ(1000000), .BAUD(100000), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .letter_in(letter_in), .letter_stb(letter_stb),
    .tx(tx), .tx_busy(tx_busy), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; bit gap; } exp_t;
  exp_t q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // UART receiver: phase 0 is the first low cycle, bits sampled at mid-bit.
  bit         rx_active = 0;
  int         ph, start_cyc, prev_start;
  logic       rx_start, rx_stop;
  logic [7:0] rx_byte;
  always @(negedge clk) begin
    if (rst) begin
      rx_active = 0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active = 1;
        ph        = 0;
        start_cyc = cyc;
      end
    end else begin
      ph++;
      if (ph % 10 == 5) begin
        if (ph / 10 == 0) rx_start = tx;
        else if (ph / 10 <= 8) rx_byte[ph/10 - 1] = tx;
        else begin
          rx_stop   = tx;
          rx_active = 0;
          if (q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_frame: got 0x%02h expected none", rx_byte);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("frame_data", 32'(rx_byte), 32'(e.data));
            chk("start_bit", 32'(rx_start), 32'd0);
            chk("stop_bit", 32'(rx_stop), 32'd1);
            if (e.gap) chk("frame_gap", 32'(start_cyc - prev_start), 32'd101);
          end
          prev_start = start_cyc;
        end
      end
    end
  end

  task automatic drain(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] codes3 [3];
    int busy_cycles;
    int maxc;
    codes3 = '{8'h53, 8'hFF, 8'h4F};

    rst = 1'b1; letter_in = 8'h00; letter_stb = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(tx_busy), 32'd0);
    chk("reset_count", 32'(fifo_count), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);

    // Single 'A': latency and busy duration
    letter_in = 8'h41; letter_stb = 1'b1;
    q.push_back('{8'h41, 1'b0});
    @(posedge clk); #1;
    chk("lat_count1", 32'(fifo_count), 32'd1);
    chk("lat_tx_idle", 32'(tx), 32'd1);
    @(negedge clk); letter_stb = 1'b0;
    @(posedge clk); #1;
    chk("lat_tx_low", 32'(tx), 32'd0);
    chk("lat_count0", 32'(fifo_count), 32'd0);
    busy_cycles = tx_busy ? 1 : 0;
    for (int i = 0; i < 200 && tx_busy; i++) begin
      @(posedge clk); #1;
      if (tx_busy) busy_cycles++;
    end
    chk("busy_cycles", 32'(busy_cycles), 32'd100);
    drain(300);

    // 'S', word space, 'O' back to back
    maxc = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      letter_in = codes3[i]; letter_stb = 1'b1;
    end
    q.push_back('{8'h53, 1'b0});
    q.push_back('{8'h20, 1'b1});
    q.push_back('{8'h4F, 1'b1});
    @(negedge clk); letter_stb = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      @(negedge clk);
    end
    chk("peak_count", 32'(maxc), 32'd2);
    drain(500);

    // 18 strobes: 17 accepted, last one overflows
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 17) begin
        chk("burst_count16", 32'(fifo_count), 32'd16);
        chk("burst_no_ovf", 32'(overflow), 32'd0);
      end
      letter_in = 8'h41 + 8'(i); letter_stb = 1'b1;
      if (i < 17) q.push_back('{8'h41 + 8'(i), i > 0});
    end
    @(negedge clk); letter_stb = 1'b0;
    chk("burst_ovf", 32'(overflow), 32'd1);
    chk("burst_count_after", 32'(fifo_count), 32'd16);
    drain(2500);
    repeat (100) @(negedge clk);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    repeat (5) @(negedge clk);

    // Unrecognised code
    letter_in = 8'h00; letter_stb = 1'b1;
`ifdef MORSE_TX_INVALID_EN
    q.push_back('{8'h3F, 1'b0});
`endif
    @(negedge clk); letter_stb = 1'b0;
`ifdef MORSE_TX_INVALID_EN
    chk("invalid_count", 32'(fifo_count), 32'd1);
`else
    chk("invalid_count", 32'(fifo_count), 32'd0);
`endif
    chk("invalid_no_ovf", 32'(overflow), 32'd0);
    drain(300);
    repeat (150) @(negedge clk);
    chk("invalid_idle", 32'(tx_busy), 32'd0);

    // Reset 35 cycles into a frame with one character still buffered
    letter_in = 8'h4B; letter_stb = 1'b1;
    @(negedge clk); letter_in = 8'h4D;
    @(negedge clk); letter_stb = 1'b0;
    for (int i = 0; i < 20 && tx !== 1'b0; i++) @(negedge clk);
    chk("abort_frame_started", 32'(tx), 32'd0);
    repeat (35) @(negedge clk);
    chk("abort_pre_count", 32'(fifo_count), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_count", 32'(fifo_count), 32'd0);
    chk("abort_busy", 32'(tx_busy), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("abort_no_frames", 32'(tx_busy), 32'd0);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
